// File: rtl/horizontal_out_router.sv
// Frame-position router for multiplier samples: splits each frame into head/body/tail
// regions, emits ROM bank write selects and an in-region address, all registered.
module horizontal_out_router #(
  parameter int P_WIDTH = 64,
  parameter int SEG_LEN = 4,
  parameter int NSEG    = 4,
  parameter int N_ROM   = 8,
  localparam int FRAME_LEN = NSEG * SEG_LEN,
  localparam int CW        = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1,
  localparam int SW        = $clog2(NSEG)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [P_WIDTH-1:0]     in_data,
  input  logic                   in_valid,
  input  logic                   sync_clr,
  input  logic                   err_clr,
  output logic [P_WIDTH-1:0]     head_data,
  output logic [P_WIDTH-1:0]     body_data,
  output logic [P_WIDTH-1:0]     tail_data,
  output logic                   out_valid,
  output logic                   rom0_w,
  output logic [2*(N_ROM-1)-1:0] rom_w,
  output logic [SW-1:0]          seg_idx,
  output logic [CW-1:0]          wr_addr,
  output logic                   frame_done,
  output logic                   frame_err
);

  localparam int LOG_SEG = $clog2(SEG_LEN);

  logic [CW-1:0]          cnt, cnt_nxt, idx, off, wr_d;
  logic [SW-1:0]          seg;
  logic                   is_head, is_tail, is_last;
  logic [1:0]             odd_code, even_code;
  logic [2*(N_ROM-1)-1:0] rom_w_d;

  always_comb begin
    idx     = sync_clr ? '0 : cnt;
    seg     = SW'(idx >> LOG_SEG);
    off     = idx & CW'(SEG_LEN - 1);
    is_head = (seg == '0);
    is_tail = (seg == SW'(NSEG - 1));
    is_last = (idx == CW'(FRAME_LEN - 1));
    wr_d    = (is_head || is_tail) ? off : idx - CW'(SEG_LEN);

    // Body segments alternate odd-bank codes 1,2,1,... starting at segment 1.
    if (is_head) begin
      odd_code  = 2'd0;
      even_code = 2'd2;
    end else if (is_tail) begin
      odd_code  = 2'd0;
      even_code = 2'd1;
    end else begin
      odd_code  = seg[0] ? 2'd1 : 2'd2;
      even_code = 2'd0;
    end

    rom_w_d = '0;
    for (int b = 1; b < N_ROM; b++) begin
      rom_w_d[2*(b-1) +: 2] = (b % 2 == 1) ? odd_code : even_code;
    end

    if (in_valid)
      cnt_nxt = is_last ? '0 : idx + CW'(1);
    else if (sync_clr)
      cnt_nxt = '0;
    else
      cnt_nxt = cnt;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      cnt        <= '0;
      head_data  <= '0;
      body_data  <= '0;
      tail_data  <= '0;
      out_valid  <= 1'b0;
      rom0_w     <= 1'b0;
      rom_w      <= '0;
      seg_idx    <= '0;
      wr_addr    <= '0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      out_valid  <= in_valid;
      head_data  <= (in_valid && is_head) ? in_data : '0;
      tail_data  <= (in_valid && is_tail) ? in_data : '0;
      body_data  <= (in_valid && !is_head && !is_tail) ? in_data : '0;
      rom0_w     <= in_valid && is_head;
      rom_w      <= in_valid ? rom_w_d : '0;
      seg_idx    <= in_valid ? seg : '0;
      wr_addr    <= in_valid ? wr_d : '0;
      frame_done <= in_valid && is_last;
      // A truncating resync wins over a same-cycle clear.
      if (sync_clr && (cnt != '0))
        frame_err <= 1'b1;
      else if (err_clr)
        frame_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_horizontal_out_router.sv
// Bench for horizontal_out_router: default and (SEG_LEN=2, NSEG=5, N_ROM=4) instances
// share stimulus; both are checked against an integer reference model plus constant tables.
module tb_horizontal_out_router;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] in_data;
  logic        in_valid, sync_clr, err_clr;

  logic [63:0] h1, b1, t1, h2, b2, t2;
  logic        v1, v2, r01, r02, fd1, fd2, fe1, fe2;
  logic [13:0] rw1;
  logic [5:0]  rw2;
  logic [1:0]  s1;
  logic [2:0]  s2;
  logic [3:0]  w1, w2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  horizontal_out_router dut1 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .sync_clr(sync_clr), .err_clr(err_clr), .head_data(h1), .body_data(b1),
    .tail_data(t1), .out_valid(v1), .rom0_w(r01), .rom_w(rw1), .seg_idx(s1),
    .wr_addr(w1), .frame_done(fd1), .frame_err(fe1));

  horizontal_out_router #(.P_WIDTH(64), .SEG_LEN(2), .NSEG(5), .N_ROM(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .sync_clr(sync_clr), .err_clr(err_clr), .head_data(h2), .body_data(b2),
    .tail_data(t2), .out_valid(v2), .rom0_w(r02), .rom_w(rw2), .seg_idx(s2),
    .wr_addr(w2), .frame_done(fd2), .frame_err(fe2));

  typedef struct packed {
    logic        valid;
    logic [63:0] head, body, tail;
    logic        rom0;
    logic [63:0] rom_w, seg, wr;
    logic        done, err;
  } exp_t;

  typedef struct {
    logic        v;
    logic [63:0] d;
    logic        sc, ec;
    int          port;   // 0 none, 1 head, 2 body, 3 tail
    int          wr, seg;
    logic        rom0;
    int          odd, even;
    logic        done, err;
  } vec_t;

  vec_t tbl[$];

  int p_sl[2] = '{4, 2};
  int p_ns[2] = '{4, 5};
  int p_nr[2] = '{8, 4};
  int m_cnt[2];
  int m_err[2];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: frame position as a plain integer, region and codes from the rules.
  task automatic model_step(input int c, output exp_t e);
    int idx, s, o, fl, oc, evc, old;
    e = '0;
    if (rst_n) begin
      m_cnt[c] = 0;
      m_err[c] = 0;
      return;
    end
    old = m_cnt[c];
    idx = sync_clr ? 0 : old;
    fl  = p_sl[c] * p_ns[c];
    if (in_valid) begin
      s = idx / p_sl[c];
      o = idx % p_sl[c];
      e.valid = 1'b1;
      e.seg   = 64'(s);
      if (s == 0) begin
        e.head = in_data; e.wr = 64'(o); e.rom0 = 1'b1; oc = 0; evc = 2;
      end else if (s == p_ns[c] - 1) begin
        e.tail = in_data; e.wr = 64'(o); oc = 0; evc = 1;
      end else begin
        e.body = in_data; e.wr = 64'(idx - p_sl[c]); oc = ((s - 1) % 2) + 1; evc = 0;
      end
      for (int b = 1; b < p_nr[c]; b++)
        e.rom_w = e.rom_w | (64'((b % 2 == 1) ? oc : evc) << (2 * (b - 1)));
      e.done   = (idx == fl - 1);
      m_cnt[c] = (idx == fl - 1) ? 0 : idx + 1;
    end else if (sync_clr) begin
      m_cnt[c] = 0;
    end
    if (sync_clr && old != 0) m_err[c] = 1;
    else if (err_clr) m_err[c] = 0;
    e.err = (m_err[c] != 0);
  endtask

  task automatic cmp1(input exp_t e);
    chk("d1.valid", 64'(v1), 64'(e.valid));
    chk("d1.head", h1, e.head);
    chk("d1.body", b1, e.body);
    chk("d1.tail", t1, e.tail);
    chk("d1.rom0", 64'(r01), 64'(e.rom0));
    chk("d1.rom_w", 64'(rw1), e.rom_w);
    chk("d1.seg", 64'(s1), e.seg);
    chk("d1.wr", 64'(w1), e.wr);
    chk("d1.done", 64'(fd1), 64'(e.done));
    chk("d1.err", 64'(fe1), 64'(e.err));
  endtask

  task automatic cmp2(input exp_t e);
    chk("d2.valid", 64'(v2), 64'(e.valid));
    chk("d2.head", h2, e.head);
    chk("d2.body", b2, e.body);
    chk("d2.tail", t2, e.tail);
    chk("d2.rom0", 64'(r02), 64'(e.rom0));
    chk("d2.rom_w", 64'(rw2), e.rom_w);
    chk("d2.seg", 64'(s2), e.seg);
    chk("d2.wr", 64'(w2), e.wr);
    chk("d2.done", 64'(fd2), 64'(e.done));
    chk("d2.err", 64'(fe2), 64'(e.err));
  endtask

  task automatic step(input logic v, input logic [63:0] d, input logic sc, input logic ec);
    exp_t e0, e1;
    in_valid = v; in_data = d; sync_clr = sc; err_clr = ec;
    model_step(0, e0);
    model_step(1, e1);
    @(posedge clk);
    #1;
    cmp1(e0);
    cmp2(e1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".d1"}, {h1 | b1 | t1, 64'(rw1)} == '0 ? 64'({v1, r01, s1, w1, fd1, fe1}) : 64'hDEAD, 64'd0);
    chk({tag, ".d2"}, {h2 | b2 | t2, 64'(rw2)} == '0 ? 64'({v2, r02, s2, w2, fd2, fe2}) : 64'hDEAD, 64'd0);
  endtask

  function automatic logic [63:0] rom8(input int odd, input int even);
    logic [63:0] r = '0;
    for (int b = 1; b < 8; b++) r = r | (64'((b % 2 == 1) ? odd : even) << (2 * (b - 1)));
    return r;
  endfunction

  function automatic vec_t mk(input logic v, input logic [63:0] d, input logic sc, input logic ec,
                              input int port, input int wr, input int seg, input logic rom0,
                              input int odd, input int even, input logic done, input logic err);
    vec_t x;
    x.v = v; x.d = d; x.sc = sc; x.ec = ec; x.port = port; x.wr = wr; x.seg = seg;
    x.rom0 = rom0; x.odd = odd; x.even = even; x.done = done; x.err = err;
    return x;
  endfunction

  initial begin
    int odd2[10];
    int even2[10];
    logic [63:0] ex;

    // Default-geometry stream, gap, resync and error-clear sequence.
    for (int k = 0; k < 4; k++)  tbl.push_back(mk(1, 64'(k + 1), 0, 0, 1, k,     0, 1, 0, 2, 0, 0));
    for (int k = 4; k < 8; k++)  tbl.push_back(mk(1, 64'(k + 1), 0, 0, 2, k - 4, 1, 0, 1, 0, 0, 0));
    for (int k = 8; k < 12; k++) tbl.push_back(mk(1, 64'(k + 1), 0, 0, 2, k - 4, 2, 0, 2, 0, 0, 0));
    for (int k = 12; k < 16; k++)
      tbl.push_back(mk(1, 64'(k + 1), 0, 0, 3, k - 12, 3, 0, 0, 1, k == 15, 0));
    tbl.push_back(mk(1, 64'h21, 0, 0, 1, 0, 0, 1, 0, 2, 0, 0));
    tbl.push_back(mk(1, 64'h22, 0, 0, 1, 1, 0, 1, 0, 2, 0, 0));
    tbl.push_back(mk(1, 64'h23, 0, 0, 1, 2, 0, 1, 0, 2, 0, 0));
    tbl.push_back(mk(1, 64'h24, 0, 0, 1, 3, 0, 1, 0, 2, 0, 0));
    tbl.push_back(mk(1, 64'h25, 0, 0, 2, 0, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 64'h26, 0, 0, 2, 1, 1, 0, 1, 0, 0, 0));
    for (int k = 0; k < 3; k++) tbl.push_back(mk(0, 64'hFFFF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 64'h27, 0, 0, 2, 2, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 64'h28, 0, 0, 2, 3, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 64'h29, 0, 0, 2, 4, 2, 0, 2, 0, 0, 0));
    tbl.push_back(mk(1, 64'h2A, 1, 0, 1, 0, 0, 1, 0, 2, 0, 1));
    tbl.push_back(mk(0, 64'h0,  0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 64'h2B, 0, 0, 1, 1, 0, 1, 0, 2, 0, 0));
    tbl.push_back(mk(1, 64'h2C, 1, 1, 1, 0, 0, 1, 0, 2, 0, 1));
    tbl.push_back(mk(0, 64'h0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 1));

    rst_n = 1'b1; in_valid = 0; in_data = '0; sync_clr = 0; err_clr = 0;
    m_cnt = '{0, 0}; m_err = '{0, 0};
    #1;
    chk_all_zero("reset");
    step(1, 64'h55, 0, 0);
    rst_n = 1'b0;

    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].d, tbl[i].sc, tbl[i].ec);
      chk("tbl.valid", 64'(v1), 64'(tbl[i].v));
      chk("tbl.head", h1, tbl[i].port == 1 ? tbl[i].d : 64'd0);
      chk("tbl.body", b1, tbl[i].port == 2 ? tbl[i].d : 64'd0);
      chk("tbl.tail", t1, tbl[i].port == 3 ? tbl[i].d : 64'd0);
      chk("tbl.wr", 64'(w1), 64'(tbl[i].wr));
      chk("tbl.seg", 64'(s1), 64'(tbl[i].seg));
      chk("tbl.rom0", 64'(r01), 64'(tbl[i].rom0));
      chk("tbl.rom_w", 64'(rw1), rom8(tbl[i].odd, tbl[i].even));
      chk("tbl.done", 64'(fd1), 64'(tbl[i].done));
      chk("tbl.err", 64'(fe1), 64'(tbl[i].err));
    end

    // Asynchronous reset in the middle of a frame, while frame_err is set.
    step(1, 64'h31, 0, 0);
    step(1, 64'h32, 0, 0);
    #2;
    rst_n = 1'b1;
    #1;
    chk_all_zero("async_rst");
    m_cnt = '{0, 0}; m_err = '{0, 0};
    step(1, 64'h99, 0, 0);
    chk_all_zero("held_rst");
    rst_n = 1'b0;
    step(1, 64'hA0, 0, 0);
    chk("rst.head", h1, 64'hA0);
    chk("rst.wr", 64'(w1), 64'd0);
    chk("rst.head2", h2, 64'hA0);

    // Narrow geometry: resync without a sample, then one full 10-sample frame.
    step(0, 64'h0, 1, 0);
    chk("d2.sc_err", 64'(fe2), 64'd1);
    step(0, 64'h0, 0, 1);
    chk("d2.ec_err", 64'(fe2), 64'd0);
    odd2  = '{0, 0, 1, 1, 2, 2, 1, 1, 0, 0};
    even2 = '{2, 2, 0, 0, 0, 0, 0, 0, 1, 1};
    for (int k = 0; k < 10; k++) begin
      step(1, 64'(16'hB0 + k), 0, 0);
      ex = 64'(odd2[k]) | (64'(even2[k]) << 2) | (64'(odd2[k]) << 4);
      chk("g2.rom_w", 64'(rw2), ex);
      chk("g2.body", b2, (k >= 2 && k <= 7) ? 64'(16'hB0 + k) : 64'd0);
      chk("g2.wr", 64'(w2), (k >= 2 && k <= 7) ? 64'(k - 2) : 64'(k % 2));
      chk("g2.done", 64'(fd2), 64'(k == 9));
    end

    // Randomized traffic with stalls, resyncs, clears and occasional resets.
    for (int n = 0; n < 600; n++) begin
      rst_n = ($urandom_range(0, 99) == 0);
      step($urandom_range(0, 3) != 0, {$urandom, $urandom},
           $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0);
    end
    rst_n = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
